// File: rtl/lsu.sv
// Load/store unit: one aligned-checked memory transaction at a time, 2-cycle best case
// (1 cycle on fault); waits indefinitely on mem_ready, upstream throttles on busy.
module lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic                  addr_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  done,
  output logic                  fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        ld_q;

  logic [1:0]  off;
  logic        accept;
  logic        legal;
  logic        misalign;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  assign off    = addr_in[1:0];
  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && addr_valid && (is_load ^ is_store);

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      case (funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
        default:                      legal = 1'b0;
      endcase
    end else begin
      legal = (funct3 <= 3'd2);
    end
  end

  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'd1:    misalign = off[0];
      2'd2:    misalign = (off != 2'd0);
      default: misalign = 1'b0;
    endcase
  end

  // Store lane steering: replicate the datum across all lanes, enables pick the target bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (funct3[1:0])
      2'd0: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{store_data[7:0]}};
      end
      2'd1: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = rd_shift;
    case (f3_q)
      3'd0:    ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    ld_ext = {24'd0, rd_shift[7:0]};
      3'd5:    ld_ext = {16'd0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
      ld_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= '0;
      load_data <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            off_q <= off;
            f3_q  <= funct3;
            ld_q  <= is_load;
            if (!legal || misalign) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr_in[31:2], 2'b00};
              mem_be    <= is_store ? st_be : 4'b1111;
              mem_wdata <= is_store ? st_wdata : 32'd0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state     <= DONE;
            done      <= 1'b1;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= '0;
            if (ld_q) load_data <= ld_ext;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-level reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr_in;
  logic        addr_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        fault;

  int errs = 0;
  int checks = 0;
  int n_done = 0;
  int exp_done = 0;
  logic [31:0] exp_load = 32'd0;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .addr_in(addr_in), .addr_valid(addr_valid),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .store_data(store_data),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .load_data(load_data), .done(done), .fault(fault)
  );

  always @(negedge clk) if (done) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: operation size in bytes and plain-arithmetic extraction.
  function automatic int op_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit ref_fault(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    ok = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    return !ok || ((a % op_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int m;
    if (!st) return 4'hF;
    m = ((1 << op_size(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (op_size(f3) == 1) return (d % 256) * 32'h01010101;
    if (op_size(f3) == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint v, span;
    if (op_size(f3) == 4) return rd;
    v    = longint'(rd) / (longint'(1) << (8 * (a % 4)));
    span = longint'(1) << (8 * op_size(f3));
    v    = v % span;
    if (f3 < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic garbage();
    addr_valid = 1'($urandom_range(0, 1));
    is_load    = 1'($urandom_range(0, 1));
    is_store   = ~is_load;
    funct3     = 3'($urandom_range(0, 2));
    addr_in    = $urandom & 32'hFFFF_FFFC;
    store_data = $urandom;
    mem_rdata  = $urandom;
  endtask

  // One operation from the cycle before accept through return to IDLE.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int w);
    bit flt;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    addr_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr_in = a; store_data = d;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    if (ld == st) begin
      addr_valid = 1'b0;
      mem_ready  = 1'b0;
      check("bad_op_busy", busy, 1'b0);
      check("bad_op_done", done, 1'b0);
      return;
    end
    flt = ref_fault(ld, f3, a);
    if (flt) begin
      garbage();
      check("flt_done", done, 1'b1);
      check("flt_fault", fault, 1'b1);
      check("flt_req", mem_req, 1'b0);
      exp_done++;
      @(negedge clk);
      addr_valid = 1'b0;
      check("flt_done_end", done, 1'b0);
      check("flt_load_hold", load_data, exp_load);
      return;
    end
    e_addr = a & 32'hFFFF_FFFC;
    e_be   = ref_be(st, f3, a);
    e_wd   = ref_wdata(f3, d);
    check("req", mem_req, 1'b1);
    check("we", mem_we, st);
    check("addr", mem_addr, e_addr);
    check("be", mem_be, e_be);
    if (st) check("wdata", mem_wdata, e_wd);
    check("req_done", done, 1'b0);
    check("req_busy", busy, 1'b1);
    for (int i = 0; i < w; i++) begin
      garbage();
      mem_ready = 1'b0;
      @(negedge clk);
      check("wait_req", mem_req, 1'b1);
      check("wait_addr", mem_addr, e_addr);
      check("wait_be", mem_be, e_be);
      if (st) check("wait_wdata", mem_wdata, e_wd);
      check("wait_done", done, 1'b0);
    end
    garbage();
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready  = 1'b0;
    addr_valid = 1'b0;
    exp_done++;
    if (ld) exp_load = ref_load(f3, a, rd);
    check("done", done, 1'b1);
    check("done_fault", fault, 1'b0);
    check("done_req", mem_req, 1'b0);
    check("done_be", mem_be, 4'd0);
    check("load_data", load_data, exp_load);
    @(negedge clk);
    check("done_end", done, 1'b0);
    check("back_idle", busy, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; addr_in = 0; addr_valid = 0; is_load = 0; is_store = 0;
    funct3 = 0; store_data = 0; mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    resetn = 1'b1;

    do_op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    do_op(1, 0, 3'd0, 32'h203, 32'h0, 32'h80123456, 0);
    check("lb_sext", load_data, 32'hFFFFFF80);
    do_op(1, 0, 3'd5, 32'h202, 32'h0, 32'hBEEF1234, 1);
    check("lhu_zext", load_data, 32'h0000BEEF);
    do_op(0, 1, 3'd0, 32'h301, 32'h000000A5, 32'h0, 0);
    do_op(0, 1, 3'd1, 32'h1001, 32'h1234, 32'h0, 0);
    do_op(1, 0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 3);
    do_op(1, 1, 3'd2, 32'h400, 32'h0, 32'h0, 0);
    do_op(0, 0, 3'd2, 32'h400, 32'h0, 32'h0, 0);

    // Reset abandons a transaction stuck in REQ.
    @(negedge clk);
    addr_valid = 1; is_load = 1; is_store = 0; funct3 = 3'd2; addr_in = 32'h500;
    @(negedge clk);
    addr_valid = 0;
    check("pre_rst_req", mem_req, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_load = 32'd0;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_load", load_data, 32'd0);
    check("mid_rst_done", done, 1'b0);
    do_op(1, 0, 3'd2, 32'h504, 32'h0, 32'h13572468, 0);

    for (int n = 0; n < 200; n++) begin
      int r;
      bit ld, st;
      r = $urandom_range(0, 9);
      ld = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      st = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : ~ld;
      do_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    check("done_count", n_done, exp_done);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
